// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared 32-bit ALU (IDLE -> EXEC -> RESP).
// Optional per-requester completion counters are built when ALU_STATS_EN is defined.
module alu_rr_arbiter #(
  parameter int DATA_W = 32,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_f,
  output logic              rsp_zf,
  output logic              rsp_of,
  output logic [STAT_W-1:0] stat_cnt0,
  output logic [STAT_W-1:0] stat_cnt1
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; requesters hold valid/op/operands stable until ready.
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              last_grant_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              id_q;
  logic              rsp_valid_q, rsp_id_q, rsp_zf_q, rsp_of_q;
  logic [DATA_W-1:0] rsp_f_q;

  logic              grant0, grant1;
  logic              hs0, hs1, rsp_hs;
  logic [DATA_W-1:0] alu_f;
  logic              alu_zf, alu_of;

  // The requester that did not win last time takes any contention.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  assign hs0    = req0_ready;
  assign hs1    = req1_ready;
  assign rsp_hs = (state_q == RESP) && rsp_valid_q && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs0 || hs1) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE) begin
      req0_ready = grant0;
      req1_ready = grant1;
    end
  end

  // ALU on the latched operands
  always_comb begin
    alu_f  = '0;
    alu_of = 1'b0;
    case (op_q)
      3'b000: alu_f = a_q & b_q;
      3'b001: alu_f = a_q | b_q;
      3'b010: alu_f = a_q ^ b_q;
      3'b011: alu_f = a_q ~^ b_q;
      3'b100: begin
        alu_f  = a_q + b_q;
        alu_of = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (alu_f[DATA_W-1] != a_q[DATA_W-1]);
      end
      3'b101: begin
        alu_f  = a_q - b_q;
        alu_of = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (alu_f[DATA_W-1] != a_q[DATA_W-1]);
      end
      3'b110: alu_f = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
      3'b111: begin
        // Shift amounts past the word width flush the result to zero.
        if (a_q >= DATA_W[DATA_W-1:0]) alu_f = '0;
        else                           alu_f = b_q << a_q[SH_W-1:0];
      end
      default: alu_f = '0;
    endcase
  end

  assign alu_zf = (alu_f == '0);

  // Operand latch and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_f_q      <= '0;
      rsp_zf_q     <= 1'b0;
      rsp_of_q     <= 1'b0;
    end else begin
      if (hs0 || hs1) begin
        op_q         <= hs1 ? req1_op : req0_op;
        a_q          <= hs1 ? req1_a  : req0_a;
        b_q          <= hs1 ? req1_b  : req0_b;
        id_q         <= hs1;
        last_grant_q <= hs1;
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_f_q     <= alu_f;
        rsp_zf_q    <= alu_zf;
        rsp_of_q    <= alu_of;
      end
      if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_zf    = rsp_zf_q;
  assign rsp_of    = rsp_of_q;

`ifdef ALU_STATS_EN
  logic [STAT_W-1:0] cnt0_q, cnt1_q;
  localparam logic [STAT_W-1:0] CNT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  // Saturating completion counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (rsp_hs) begin
      if (!rsp_id_q && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_ONE;
      if (rsp_id_q && (cnt1_q != '1))  cnt1_q <= cnt1_q + CNT_ONE;
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
`else
  assign stat_cnt0 = '0;
  assign stat_cnt1 = '0;
`endif

endmodule
